// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: twiddle output stream between twiddle_gen and the butterfly datapath.
//   master (generator): drives out_valid, out_re, out_im, out_idx, out_last; samples out_ready
//   slave  (consumer) : samples the payload; drives out_ready
// A beat transfers on a rising edge where out_valid && out_ready.
// DATA_W and IDX_W must match the generator's DATA_W and $clog2(N_POINTS)-1.
interface twiddle_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 2
);
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic        [IDX_W-1:0]  out_idx;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_re,
        output out_im,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/twiddle_gen.sv
// twiddle_gen: twiddle-factor stream for one radix-2 DIT FFT stage.
// Stores a quarter-wave cosine table (N_POINTS/4+1 entries) and folds it by symmetry to
// W = cos(2*pi*m/N) - j*sin(2*pi*m/N). A start streams N_POINTS/2 twiddles for the
// requested stage through a 2-register pipeline with valid/ready back-pressure.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start_i     request a stage sequence; accepted only while idle
//   stage_i     FFT stage, legal 0..LOG2N-1, sampled with start_i
//   inverse_i   (only with TWIDDLE_INVERSE_EN) emit conjugate twiddles for the IFFT
//   busy_o      sequence in progress
//   err_o       one-cycle pulse after an idle start with an illegal stage
//   out_bus     twiddle stream (master side of twiddle_gen_if)
//
// Build option: define TWIDDLE_INVERSE_EN to add inverse_i.
module twiddle_gen #(
    parameter  int unsigned N_POINTS = 8,
    parameter  int unsigned DATA_W   = 8,
    localparam int unsigned LOG2N    = $clog2(N_POINTS),
    localparam int unsigned STAGE_W  = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1,
    localparam int unsigned IDX_W    = LOG2N - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [STAGE_W-1:0] stage_i,
`ifdef TWIDDLE_INVERSE_EN
    input  logic               inverse_i,
`endif
    output logic               busy_o,
    output logic               err_o,
    twiddle_gen_if.master      out_bus
);

    localparam int unsigned     RomDepth = N_POINTS / 4 + 1;
    localparam logic [IDX_W-1:0] Quarter = IDX_W'(N_POINTS / 4);
    localparam logic [IDX_W-1:0] LastCnt = IDX_W'(N_POINTS / 2 - 1);
    localparam real              Pi      = 3.14159265358979323846;
    localparam real              FullScl = real'((1 << (DATA_W - 1)) - 1);

    // Symmetric round-half-away keeps +1.0 and -1.0 at equal magnitude, so the
    // most-negative code is never generated and negation cannot overflow.
    function automatic logic signed [DATA_W-1:0] cos_q(input int k);
        real x;
        int  v;
        x = $cos(2.0 * Pi * real'(k) / real'(N_POINTS)) * FullScl;
        if (x >= 0.0) v = $rtoi(x + 0.5);
        else          v = -$rtoi(0.5 - x);
        return DATA_W'(v);
    endfunction

    logic signed [DATA_W-1:0] rom [RomDepth];
    for (genvar gi = 0; gi < RomDepth; gi++) begin : g_rom
        assign rom[gi] = cos_q(gi);
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               inv_q;

    // Stage 1: exponent decoded into table addresses and the real-part sign.
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic [IDX_W-1:0] s1_addr_re_q, s1_addr_re_d;
    logic [IDX_W-1:0] s1_addr_im_q, s1_addr_im_d;
    logic             s1_neg_re_q, s1_neg_re_d;

    // Stage 2: registered outputs.
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [IDX_W-1:0]         out_idx_q, out_idx_d;
    logic signed [DATA_W-1:0] out_re_q, out_re_d;
    logic signed [DATA_W-1:0] out_im_q, out_im_d;

    logic                     advance, accept_last, legal, start_ok;
    logic [IDX_W-1:0]         k_mask, k_cur, m_cur, r_cur;
    logic signed [DATA_W-1:0] re_mag, im_mag;

    always_comb begin
        // A held beat freezes every register behind it, including the index counter.
        advance     = !(out_valid_q && !out_bus.out_ready);
        accept_last = out_valid_q && out_bus.out_ready && out_last_q;
        legal       = (32'(stage_i) < LOG2N);
        start_ok    = (state_q == StIdle) && start_i && legal;

        // Counter bits below the stage number select k; groups just repeat the pattern.
        k_mask = IDX_W'((32'd1 << stage_q) - 32'd1);
        k_cur  = cnt_q & k_mask;
        m_cur  = k_cur << (IDX_W - 32'(stage_q));
        r_cur  = m_cur - Quarter;

        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (legal) begin
                        state_d = StRun;
                        stage_d = stage_i;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (advance) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) state_d = StDrain;
                end
            end
            StDrain: begin
                if (accept_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_idx_d     = s1_idx_q;
        s1_addr_re_d = s1_addr_re_q;
        s1_addr_im_d = s1_addr_im_q;
        s1_neg_re_d  = s1_neg_re_q;
        if (advance) begin
            s1_valid_d = (state_q == StRun);
            s1_last_d  = (state_q == StRun) && (cnt_q == LastCnt);
            s1_idx_d   = m_cur;
            if (m_cur < Quarter) begin
                s1_addr_re_d = m_cur;
                s1_addr_im_d = Quarter - m_cur;
                s1_neg_re_d  = 1'b0;
            end else begin
                s1_addr_re_d = Quarter - r_cur;
                s1_addr_im_d = r_cur;
                s1_neg_re_d  = 1'b1;
            end
        end

        re_mag = rom[s1_addr_re_q];
        im_mag = rom[s1_addr_im_q];

        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q && s1_last_q;
            out_idx_d   = s1_valid_q ? s1_idx_q : '0;
            // Imaginary part is -sin for the forward transform; the conjugate drops the sign.
            out_re_d    = !s1_valid_q ? '0 : (s1_neg_re_q ? -re_mag : re_mag);
            out_im_d    = !s1_valid_q ? '0 : (inv_q ? im_mag : -im_mag);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            stage_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_idx_q     <= '0;
            s1_addr_re_q <= '0;
            s1_addr_im_q <= '0;
            s1_neg_re_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_idx_q    <= '0;
            out_re_q     <= '0;
            out_im_q     <= '0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_idx_q     <= s1_idx_d;
            s1_addr_re_q <= s1_addr_re_d;
            s1_addr_im_q <= s1_addr_im_d;
            s1_neg_re_q  <= s1_neg_re_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_idx_q    <= out_idx_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
        end
    end

`ifdef TWIDDLE_INVERSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (start_ok) begin
            inv_q <= inverse_i;
        end
    end
`else
    assign inv_q = 1'b0;
`endif

    assign busy_o            = (state_q != StIdle);
    assign err_o             = err_q;
    assign out_bus.out_valid = out_valid_q;
    assign out_bus.out_last  = out_last_q;
    assign out_bus.out_idx   = out_idx_q;
    assign out_bus.out_re    = out_re_q;
    assign out_bus.out_im    = out_im_q;

endmodule
